// File: rtl/noc_flit_source.sv
// Traffic source driving one router rx channel with req/ack flits {DEST, payload}.
// Define NOC_SOURCE_LFSR_EN to take the payload from a P-bit Fibonacci LFSR instead of the sequence count.
module noc_flit_source #(
    parameter int SIZE      = 8,
    parameter int DEST_BITS = 3,
    parameter int DEST      = 0,
    parameter int MAX_FLITS = 2,
    parameter int GAP       = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             tx_req,
    input  logic             tx_ack,
    output logic [SIZE-1:0]  tx_data,
    output logic [CNT_W-1:0] flits_sent,
    output logic             done
);

    localparam int P  = SIZE - DEST_BITS;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [DEST_BITS-1:0] DEST_F   = DEST_BITS'(DEST);
    localparam logic [CNT_W-1:0]     MAX_F    = CNT_W'(MAX_FLITS);
    localparam logic [GW-1:0]        GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_tx_req, w_req_nxt;
    logic [SIZE-1:0]  r_tx_data, w_data_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_done, w_done_nxt;
    logic [P-1:0]     r_seq, w_seq_nxt;
    logic [GW-1:0]    r_gap, w_gap_nxt;
    logic [P-1:0]     w_payload_nxt;
    logic             w_accept;

    assign w_accept  = r_tx_req & tx_ack;
    assign w_seq_nxt = w_accept ? r_seq + P'(1) : r_seq;
    assign w_cnt_nxt = (w_accept && (r_cnt != '1)) ? r_cnt + CNT_W'(1) : r_cnt;

`ifdef NOC_SOURCE_LFSR_EN
    function automatic logic [15:0] lfsr_taps(input int p);
        case (p)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0003;
        endcase
    endfunction

    localparam logic [15:0] TAPS = lfsr_taps(P);

    logic [P-1:0] r_lfsr, w_lfsr_nxt;
    logic         w_fb;

    assign w_fb          = ^(r_lfsr & TAPS[P-1:0]);
    assign w_lfsr_nxt    = w_accept ? {r_lfsr[P-2:0], w_fb} : r_lfsr;
    assign w_payload_nxt = w_lfsr_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_lfsr <= '1;
        else        r_lfsr <= w_lfsr_nxt;
    end
`else
    assign w_payload_nxt = w_seq_nxt;
`endif

    // Payload is taken from the post-acceptance value so back-to-back flits never repeat.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_tx_req;
        w_data_nxt  = r_tx_data;
        w_done_nxt  = r_done;
        w_gap_nxt   = r_gap;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_SEND;
                    w_req_nxt   = 1'b1;
                    w_data_nxt  = {DEST_F, w_payload_nxt};
                end
            end
            ST_SEND: begin
                if (w_accept) begin
                    if ((MAX_FLITS != 0) && (w_cnt_nxt == MAX_F)) begin
                        w_state_nxt = ST_DONE;
                        w_req_nxt   = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else if ((GAP == 0) && enable) begin
                        w_data_nxt = {DEST_F, w_payload_nxt};
                    end else if (GAP == 0) begin
                        w_state_nxt = ST_IDLE;
                        w_req_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_req_nxt   = 1'b0;
                        w_gap_nxt   = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap == '0) begin
                    if (enable) begin
                        w_state_nxt = ST_SEND;
                        w_req_nxt   = 1'b1;
                        w_data_nxt  = {DEST_F, w_payload_nxt};
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap - GW'(1);
                end
            end
            ST_DONE: begin
                w_req_nxt  = 1'b0;
                w_done_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_tx_req  <= 1'b0;
            r_tx_data <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_seq     <= '0;
            r_gap     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx_req  <= w_req_nxt;
            r_tx_data <= w_data_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_done_nxt;
            r_seq     <= w_seq_nxt;
            r_gap     <= w_gap_nxt;
        end
    end

    assign tx_req     = r_tx_req;
    assign tx_data    = r_tx_data;
    assign flits_sent = r_cnt;
    assign done       = r_done;

endmodule

// File: tb/tb_noc_flit_source.sv
// Scoreboard bench for noc_flit_source: five parameterisations exercised in turn.
// With NOC_SOURCE_LFSR_EN defined, flit checks compare only the destination field plus LFSR properties.
module tb_noc_flit_source;

    logic clk, rst_n, rst4_n;
    logic en1, ack1, req1, done1; logic [7:0] d1; logic [15:0] c1;
    logic en2, ack2, req2, done2; logic [7:0] d2; logic [15:0] c2;
    logic en3, ack3, req3, done3; logic [7:0] d3; logic [15:0] c3;
    logic en4, ack4, req4, done4; logic [7:0] d4; logic [15:0] c4;
    logic en6, ack6, req6, done6; logic [5:0] d6; logic [3:0]  c6;

    logic [7:0] q1[$], q2[$], q3[$], q4[$];
    logic [5:0] q6[$];
    logic [3:0] pay6[$];
    int n_vec, n_bad;

    noc_flit_source u1 (.clk(clk), .reset(rst_n), .enable(en1), .tx_req(req1), .tx_ack(ack1),
                        .tx_data(d1), .flits_sent(c1), .done(done1));
    noc_flit_source #(.DEST(5), .MAX_FLITS(3)) u2 (.clk(clk), .reset(rst_n), .enable(en2), .tx_req(req2),
                        .tx_ack(ack2), .tx_data(d2), .flits_sent(c2), .done(done2));
    noc_flit_source #(.GAP(3), .MAX_FLITS(0)) u3 (.clk(clk), .reset(rst_n), .enable(en3), .tx_req(req3),
                        .tx_ack(ack3), .tx_data(d3), .flits_sent(c3), .done(done3));
    noc_flit_source #(.MAX_FLITS(0)) u4 (.clk(clk), .reset(rst4_n), .enable(en4), .tx_req(req4),
                        .tx_ack(ack4), .tx_data(d4), .flits_sent(c4), .done(done4));
    noc_flit_source #(.SIZE(6), .DEST_BITS(2), .MAX_FLITS(0), .CNT_W(4)) u6 (.clk(clk), .reset(rst_n),
                        .enable(en6), .tx_req(req6), .tx_ack(ack6), .tx_data(d6), .flits_sent(c6), .done(done6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [31:0] got, input logic [31:0] exp, input int pw);
`ifdef NOC_SOURCE_LFSR_EN
        check(tag, got >> pw, exp >> pw);
`else
        check(tag, got, exp);
        if (pw < 0) $display("pw %0d", pw);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acceptance happens at the posedge following a negedge that sees req & ack.
    always @(negedge clk) begin
        if (req1 && ack1) begin
            if (q1.size() == 0) check("t1 accept beyond expected", 32'(q1.size()), 32'd1);
            else check_data("t1 flit", 32'(d1), 32'(q1.pop_front()), 5);
        end
        if (req2 && ack2) begin
            if (q2.size() == 0) check("t2 accept beyond expected", 32'(q2.size()), 32'd1);
            else check_data("t2 flit", 32'(d2), 32'(q2.pop_front()), 5);
        end
        if (req3 && ack3) begin
            if (q3.size() == 0) check("t3 accept beyond expected", 32'(q3.size()), 32'd1);
            else check_data("t3 flit", 32'(d3), 32'(q3.pop_front()), 5);
        end
        if (req4 && ack4) begin
            if (q4.size() == 0) check("t4 accept beyond expected", 32'(q4.size()), 32'd1);
            else check_data("t4 flit", 32'(d4), 32'(q4.pop_front()), 5);
        end
        if (req6 && ack6) begin
            pay6.push_back(d6[3:0]);
            if (q6.size() == 0) check("t6 accept beyond expected", 32'(q6.size()), 32'd1);
            else check_data("t6 flit", 32'(d6), 32'(q6.pop_front()), 4);
        end
    end

    initial begin
        n_vec = 0; n_bad = 0;
        rst_n = 1'b0; rst4_n = 1'b0;
        en1 = 0; ack1 = 0; en2 = 0; ack2 = 0; en3 = 0; ack3 = 0;
        en4 = 0; ack4 = 0; en6 = 0; ack6 = 0;
        repeat (2) tick();
        check("rst req", 32'(req1), 32'd0);
        check("rst data", 32'(d1), 32'd0);
        check("rst cnt", 32'(c1), 32'd0);
        check("rst done", 32'(done1), 32'd0);
        check("rst u6 data", 32'(d6), 32'd0);
        rst_n = 1'b1; rst4_n = 1'b1;
        tick();

        // Test 1: defaults, ack tied high
        q1.push_back(8'h00); q1.push_back(8'h01);
        ack1 = 1; en1 = 1;
        tick();
        check("t1 req first", 32'(req1), 32'd1);
        check_data("t1 data first", 32'(d1), 32'h00, 5);
        tick();
        check("t1 req second", 32'(req1), 32'd1);
        check_data("t1 data second", 32'(d1), 32'h01, 5);
        tick();
        check("t1 req after done", 32'(req1), 32'd0);
        check("t1 cnt", 32'(c1), 32'd2);
        check("t1 done", 32'(done1), 32'd1);
        repeat (3) tick();
        check("t1 req stays low", 32'(req1), 32'd0);
        check("t1 done sticky", 32'(done1), 32'd1);
        check("t1 cnt stable", 32'(c1), 32'd2);

        // Test 2: DEST=5, ack delayed four cycles per flit
        q2.push_back(8'hA0); q2.push_back(8'hA1); q2.push_back(8'hA2);
        en2 = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            repeat (4) begin
                check("t2 req held", 32'(req2), 32'd1);
                check_data("t2 data stable", 32'(d2), 32'(8'hA0 + k), 5);
                tick();
            end
            ack2 = 1;
            tick();
            ack2 = 0;
        end
        check("t2 req after done", 32'(req2), 32'd0);
        check("t2 done", 32'(done2), 32'd1);
        check("t2 cnt", 32'(c2), 32'd3);

        // Test 3: GAP=3 unbounded, ack tied high
        for (int k = 0; k < 4; k++) q3.push_back(8'(k));
        ack3 = 1; en3 = 1;
        tick();
        for (int i = 0; i < 13; i++) begin
            check("t3 req pattern", 32'(req3), 32'(i % 4 == 0));
            if (i == 12) en3 = 0;
            tick();
        end
        repeat (5) tick();
        check("t3 req idle", 32'(req3), 32'd0);
        check("t3 done low", 32'(done3), 32'd0);
        check("t3 cnt", 32'(c3), 32'd4);

        // Test 4: enable dropped during a stall
        en4 = 1; ack4 = 0; q4.push_back(8'h00);
        tick();
        check("t4 req up", 32'(req4), 32'd1);
        check_data("t4 data0", 32'(d4), 32'h00, 5);
        repeat (2) tick();
        en4 = 0;
        tick();
        check("t4 req held after enable drop", 32'(req4), 32'd1);
        check_data("t4 data held", 32'(d4), 32'h00, 5);
        ack4 = 1;
        tick();
        ack4 = 0;
        check("t4 req low after accept", 32'(req4), 32'd0);
        tick();
        check("t4 stays idle", 32'(req4), 32'd0);
        check("t4 cnt1", 32'(c4), 32'd1);
        q4.push_back(8'h01); en4 = 1;
        tick();
        check("t4 req resume", 32'(req4), 32'd1);
        check_data("t4 seq continues", 32'(d4), 32'h01, 5);
        ack4 = 1;
        tick();
        ack4 = 0; en4 = 0;
        check("t4 back-to-back req", 32'(req4), 32'd1);
        check_data("t4 pending data", 32'(d4), 32'h02, 5);
        check("t4 cnt2", 32'(c4), 32'd2);

        // Test 5: asynchronous reset mid-handshake
        #2 rst4_n = 0;
        #1;
        check("t5 async req", 32'(req4), 32'd0);
        check("t5 async data", 32'(d4), 32'd0);
        check("t5 async cnt", 32'(c4), 32'd0);
        check("t5 async done", 32'(done4), 32'd0);
        tick();
        rst4_n = 1;
        tick();
        en4 = 1; q4.push_back(8'h00);
        tick();
        check("t5 req after reset", 32'(req4), 32'd1);
        check_data("t5 payload restarts", 32'(d4), 32'h00, 5);
        en4 = 0; ack4 = 1;
        tick();
        ack4 = 0;
        check("t5 req low", 32'(req4), 32'd0);
        check("t5 cnt", 32'(c4), 32'd1);

        // Test 6: 4-bit payload wrap and 4-bit count saturation
        for (int k = 0; k < 18; k++) q6.push_back(6'(k % 16));
        ack6 = 1; en6 = 1;
        for (int k = 0; k < 18; k++) begin
            tick();
            if (k == 17) en6 = 0;
        end
        tick();
        check("t6 req idle", 32'(req6), 32'd0);
        check("t6 cnt saturated", 32'(c6), 32'hF);
        check("t6 done low", 32'(done6), 32'd0);
        check("t6 accept count", 32'(pay6.size()), 32'd18);

`ifdef NOC_SOURCE_LFSR_EN
        if (pay6.size() == 18) begin
            int dup;
            dup = 0;
            for (int i = 0; i < 15; i++) begin
                check("t6 lfsr nonzero", 32'(pay6[i] != 4'd0), 32'd1);
                for (int j = 0; j < i; j++) if (pay6[i] == pay6[j]) dup++;
            end
            check("t6 lfsr distinct", 32'(dup), 32'd0);
            check("t6 lfsr repeat", 32'(pay6[15]), 32'(pay6[0]));
            check("t6 lfsr first", 32'(pay6[0]), 32'hF);
        end
`endif

        check("t1 queue drained", 32'(q1.size()), 32'd0);
        check("t2 queue drained", 32'(q2.size()), 32'd0);
        check("t3 queue drained", 32'(q3.size()), 32'd0);
        check("t4 queue drained", 32'(q4.size()), 32'd0);
        check("t6 queue drained", 32'(q6.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/noc_flit_source.md
Name: noc_flit_source

Overview:
- Parametrised traffic source for router testbenches and on-chip self-test.
- Drives one router rx channel using the codebase req/ack flit handshake.
- Emits a bounded or unbounded stream of flits. Each flit carries a destination field and a sequence payload.
- Supports programmable inter-flit gaps and start/stop gating; reports progress and completion.

Parameters:
- SIZE, 8, flit width in bits.
- DEST_BITS, 3, width of destination field in flit MSBs; must satisfy 1 <= DEST_BITS < SIZE.
- DEST, 0, destination value placed in flit[SIZE-1:SIZE-DEST_BITS].
- MAX_FLITS, 2, flits to send before done; 0 = unbounded.
- GAP, 0, idle cycles with tx_req low between an accepted flit and the next request.
- CNT_W, 16, width of flits_sent counter.

Ports:
- clk  input  1  clock, all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  permits starting new flits.
- tx_req  output  1  flit valid; held high until accepted.
- tx_ack  input  1  router accepts flit when high at a posedge with tx_req high.
- tx_data  output  SIZE  flit; stable while tx_req high.
- flits_sent  output  CNT_W  accepted-flit count; saturates at all-ones.
- done  output  1  high once MAX_FLITS flits are accepted.

Behaviour:
- Reset (reset low, async): tx_req=0, tx_data=0, flits_sent=0, done=0, seq=0, gap counter=0, state=IDLE. Takes effect immediately, including mid-handshake; the pending flit is dropped and not counted.
- Flit format: tx_data = {DEST[DEST_BITS-1:0], payload}; payload width P = SIZE-DEST_BITS.
  - Payload = seq, which increments mod 2^P on each acceptance and wraps silently.
- Transfer: a flit is accepted on a posedge where tx_req=1 and tx_ack=1. tx_ack while tx_req=0 is ignored.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - If enable=1, go to SEND at the next posedge, with tx_req=1 and tx_data=current flit. First request appears one cycle after enable is sampled high.
  - Otherwise stay in IDLE.
- SEND:
  - Hold tx_req and tx_data until acceptance.
  - On acceptance, flits_sent++ (saturating) and seq++.
  - If MAX_FLITS!=0 and the new count == MAX_FLITS: go to DONE with tx_req=0 and done=1 in the same edge.
  - Else if GAP==0 and enable=1: stay in SEND with the next flit. Back-to-back, one flit per cycle under constant ack.
  - Else if GAP==0 and enable=0: go to IDLE with tx_req=0.
  - Else: go to GAP with tx_req=0 and gap counter loaded with GAP-1.
- GAP:
  - Decrement the gap counter each cycle.
  - When the counter is 0 and enable=1: go to SEND (tx_req=1).
  - When the counter is 0 and enable=0: go to IDLE.
  - Net effect: exactly GAP cycles with tx_req low between flits when enable stays high.
- DONE: terminal. tx_req=0 and done=1 until reset; enable and tx_ack are ignored.
- Deassertion of enable never withdraws an asserted tx_req; it only blocks the next request.
- tx_data holds its last value when tx_req=0. Checkers must not rely on it.
- MAX_FLITS=0: DONE is never entered and done stays 0.

Optional Feature:
- Macro: NOC_SOURCE_LFSR_EN.
- Defined:
  - Payload comes from a P-bit Fibonacci LFSR, maximal-length taps for P in 2..16.
  - Reset value is all-ones.
  - Advances only on acceptance.
  - seq still counts but is not emitted.
- Undefined: payload = seq (incrementing) and no LFSR logic is synthesised.

Test Plan:
1. Defaults (SIZE=8, DEST_BITS=3, DEST=0, MAX_FLITS=2); enable=1; tx_ack tied 1 -> tx_data 0x00 then 0x01 on consecutive cycles; then tx_req=0, flits_sent=2, done=1 permanently.
2. DEST=5, MAX_FLITS=3, tx_ack delayed 4 cycles per flit -> tx_req held high and tx_data stable at 0xA0, 0xA1, 0xA2 through each stall; exactly 3 acceptances.
3. GAP=3, MAX_FLITS=0, ack tied 1 -> tx_req pattern 1,0,0,0,1,0,0,0,...; done stays 0.
4. enable dropped mid-stall with ack low -> tx_req stays high until ack; after acceptance tx_req=0, IDLE; re-enable resumes with seq continuing (no repeat).
5. reset asserted while tx_req=1 and ack low -> outputs 0 asynchronously, before the next clk edge; after release, first flit payload 0 again.
6. SIZE=6, DEST_BITS=2, MAX_FLITS=0, ack tied 1 -> payload wraps 15 -> 0 at the 17th flit.
   - With NOC_SOURCE_LFSR_EN: 15 distinct nonzero payloads, then repeat.
